alu_muldiv: RTL

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// alu_muldiv : iterative shift-add multiplier / restoring divider (RV M-ext).
// Divider datapath present only with `define ALU_MULDIV_DIV_EN.   Rev 1.0
// ============================================================================
module alu_muldiv #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            alu_muldiv_stb_i,
    input  logic [4:0]      alu_muldiv_funct_i,
    input  logic [XLEN-1:0] alu_muldiv_op1_i,
    input  logic [XLEN-1:0] alu_muldiv_op2_i,
    output logic [XLEN-1:0] alu_muldiv_res_o,
    output logic            alu_muldiv_done_o,
    output logic            alu_muldiv_busy_o
);

    localparam int N_ITER = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W  = $clog2(N_ITER + 1);

    localparam logic [4:0] F_MUL    = 5'b01110;
    localparam logic [4:0] F_MULH   = 5'b01111;
    localparam logic [4:0] F_MULHSU = 5'b10000;
    localparam logic [4:0] F_MULHU  = 5'b10001;
`ifdef ALU_MULDIV_DIV_EN
    localparam logic [4:0] F_DIV    = 5'b10010;
    localparam logic [4:0] F_DIVU   = 5'b10011;
    localparam logic [4:0] F_REM    = 5'b10100;
    localparam logic [4:0] F_REMU   = 5'b10101;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          funct_q, funct_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic                is_mul, mul_lo, sgn1, sgn2;
    logic                op1_neg, op2_neg, neg_calc;
    logic [XLEN-1:0]     mag1, mag2;
    logic [2*XLEN-1:0]   step_next, full;
    logic [XLEN-1:0]     fix_res;

    logic [BITS_PER_CYCLE-1:0]      mul_digit;
    logic [XLEN+BITS_PER_CYCLE-1:0] mul_pp, mul_sum;
    logic [2*XLEN-1:0]              mul_next;

`ifdef ALU_MULDIV_DIV_EN
    logic                is_div, is_rem;
    logic [XLEN-1:0]     div_r, div_qt, div_val;
    logic [XLEN:0]       div_trial;
    logic [2*XLEN-1:0]   div_next;
`endif

    always_comb begin
        is_mul = 1'b0;
        mul_lo = 1'b0;
        sgn1   = 1'b0;
        sgn2   = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
        is_div = 1'b0;
        is_rem = 1'b0;
`endif
        case (funct_q)
            F_MUL:    begin is_mul = 1'b1; mul_lo = 1'b1; end
            F_MULH:   begin is_mul = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
            F_MULHSU: begin is_mul = 1'b1; sgn1 = 1'b1; end
            F_MULHU:  begin is_mul = 1'b1; end
`ifdef ALU_MULDIV_DIV_EN
            F_DIV:    begin is_div = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
            F_DIVU:   begin is_div = 1'b1; end
            F_REM:    begin is_div = 1'b1; is_rem = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
            F_REMU:   begin is_div = 1'b1; is_rem = 1'b1; end
`endif
            default:  ;
        endcase
    end

    // Raw operands sit in prod_q[XLEN-1:0] / b_q until the first CALC cycle
    // replaces them with magnitudes; the product is commutative so both units
    // share this layout.
    assign op1_neg = sgn1 & prod_q[XLEN-1];
    assign op2_neg = sgn2 & b_q[XLEN-1];
    assign mag1    = op1_neg ? (-prod_q[XLEN-1:0]) : prod_q[XLEN-1:0];
    assign mag2    = op2_neg ? (-b_q) : b_q;

    always_comb begin
        neg_calc = op1_neg ^ op2_neg;
`ifdef ALU_MULDIV_DIV_EN
        // Divide by zero keeps the all-ones quotient un-negated.
        if (is_rem)
            neg_calc = op1_neg;
        else if (is_div && (b_q == '0))
            neg_calc = 1'b0;
`endif
    end

    assign mul_digit = prod_q[BITS_PER_CYCLE-1:0];
    assign mul_pp    = (XLEN+BITS_PER_CYCLE)'(b_q) * (XLEN+BITS_PER_CYCLE)'(mul_digit);
    assign mul_sum   = (XLEN+BITS_PER_CYCLE)'(prod_q[2*XLEN-1:XLEN]) + mul_pp;
    assign mul_next  = {mul_sum, prod_q[XLEN-1:BITS_PER_CYCLE]};

`ifdef ALU_MULDIV_DIV_EN
    always_comb begin
        div_r     = prod_q[2*XLEN-1:XLEN];
        div_qt    = prod_q[XLEN-1:0];
        div_trial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            div_trial = {div_r, div_qt[XLEN-1]};
            div_qt    = {div_qt[XLEN-2:0], 1'b0};
            if (div_trial >= {1'b0, b_q}) begin
                div_trial = div_trial - {1'b0, b_q};
                div_qt[0] = 1'b1;
            end
            div_r = div_trial[XLEN-1:0];
        end
        div_next = {div_r, div_qt};
    end
`endif

    always_comb begin
        step_next = mul_next;
`ifdef ALU_MULDIV_DIV_EN
        if (is_div)
            step_next = div_next;
`endif
    end

    assign full = neg_q ? (-prod_q) : prod_q;

    always_comb begin
        fix_res = '0;
        if (is_mul)
            fix_res = mul_lo ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
`ifdef ALU_MULDIV_DIV_EN
        div_val = is_rem ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
        if (is_div)
            fix_res = neg_q ? (-div_val) : div_val;
`endif
    end

    // CALC count 0 prepares magnitudes; counts 1..N_ITER retire the digits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        funct_d = funct_q;
        b_d     = b_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (alu_muldiv_stb_i) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    funct_d = alu_muldiv_funct_i;
                    prod_d  = {{XLEN{1'b0}}, alu_muldiv_op1_i};
                    b_d     = alu_muldiv_op2_i;
                end
            end
            S_CALC: begin
                if (cnt_q == '0) begin
                    prod_d = {{XLEN{1'b0}}, mag1};
                    b_d    = mag2;
                    neg_d  = neg_calc;
                end else begin
                    prod_d = step_next;
                end
                if (cnt_q == CNT_W'(N_ITER))
                    state_d = S_FIX;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            S_FIX: begin
                res_d   = fix_res;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            funct_q <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            funct_q <= funct_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign alu_muldiv_res_o  = res_q;
    assign alu_muldiv_done_o = done_q;
    assign alu_muldiv_busy_o = busy_q;

endmodule
`default_nettype wire
